// File: rtl/crc22_pkg.sv
// Shared CRC-22 definitions for the ALCT framed word stream (x^22 + x + 1).
// Used by the receive-side checker and reusable by the transmit-side generator.
package crc22_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CRC_W  = 22;
   localparam int unsigned HALF_W = CRC_W / 2;
   localparam int unsigned WORD_W = 19;
   localparam int unsigned MARK_W = 5;
   localparam int unsigned CNT_W  = 12;

   localparam logic [CRC_W-1:0]  POLY = 22'h000003;
   // Upper bits of both CRC words: nibble 0xD followed by a zero bit
   localparam logic [MARK_W-1:0] MARK = 5'b11010;

   typedef enum logic [2:0] {
      StIdle,
      StAccum,
      StCrcLo,
      StCrcHi,
      StDone
   } state_e;

   // One data word through the CRC register, MSB first
   function automatic logic [CRC_W-1:0] crc22_next(input logic [CRC_W-1:0]  crc,
                                                   input logic [DATA_W-1:0] w);
      logic [CRC_W-1:0] c;
      logic             t;
      c = crc;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         t = w[i] ^ c[CRC_W-1];
         c = {c[CRC_W-2:0], 1'b0} ^ (t ? POLY : '0);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc22_check_if.sv
// Frame word bus into the CRC-22 checker and its per-frame result.
// With CRC22_CHECK_WORDCNT_EN defined the bus also carries word_cnt.
interface crc22_check_if;
   import crc22_pkg::*;

   logic [WORD_W-1:0] d;
   logic              valid;
   logic              sof;
   logic              eof;
   logic              done;
   logic              crc_ok;
   logic              crc_err;
   logic [CRC_W-1:0]  calc_crc;
   logic [CRC_W-1:0]  rx_crc;
`ifdef CRC22_CHECK_WORDCNT_EN
   logic [CNT_W-1:0]  word_cnt;

   modport master (
      output d, valid, sof, eof,
      input  done, crc_ok, crc_err, calc_crc, rx_crc, word_cnt
   );
   modport slave (
      input  d, valid, sof, eof,
      output done, crc_ok, crc_err, calc_crc, rx_crc, word_cnt
   );
`else
   modport master (
      output d, valid, sof, eof,
      input  done, crc_ok, crc_err, calc_crc, rx_crc
   );
   modport slave (
      input  d, valid, sof, eof,
      output done, crc_ok, crc_err, calc_crc, rx_crc
   );
`endif

endinterface

// File: rtl/crc22_step.sv
// Combinational CRC-22 update over one 16-bit payload word.
module crc22_step
   import crc22_pkg::*;
(
   input  logic [CRC_W-1:0]  crc_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CRC_W-1:0]  crc_o
);

   // Next CRC after shifting all payload bits in
   always_comb begin
      crc_o = crc22_next(crc_i, data_i);
   end

endmodule

// File: rtl/crc22_check.sv
// Receive-side CRC-22 checker: header, data words, CRC-low, CRC-high.
// Optional feature macro: CRC22_CHECK_WORDCNT_EN (data-word counter, word_cnt output).
module crc22_check
   import crc22_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   crc22_check_if.slave bus
);

   state_e            state_q, state_d;
   logic [CRC_W-1:0]  ncrc_q, ncrc_d;
   logic [CRC_W-1:0]  ncrc_step;
   logic [HALF_W-1:0] rx_lo_q, rx_lo_d;
   logic              mark_err_q, mark_err_d;
   logic              done_q, done_d;
   logic              crc_ok_q, crc_ok_d;
   logic              crc_err_q, crc_err_d;
   logic [CRC_W-1:0]  calc_crc_q, calc_crc_d;
   logic [CRC_W-1:0]  rx_crc_q, rx_crc_d;
`ifdef CRC22_CHECK_WORDCNT_EN
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
`endif

   logic              start;
   logic              mark_good;
   logic              frame_ok;
   logic [CRC_W-1:0]  rx_full;
   logic              unused_d;

   crc22_step u_step (
      .crc_i  (ncrc_q),
      .data_i (bus.d[DATA_W-1:0]),
      .crc_o  (ncrc_step)
   );

   assign start     = bus.valid & bus.sof;
   assign mark_good = (bus.d[DATA_W-1:DATA_W-MARK_W] == MARK);
   // Received CRC as it will be once the current word is taken as CRC-high
   assign rx_full   = {bus.d[HALF_W-1:0], rx_lo_q};
   // dav and the spare top bits carry no checked information
   assign unused_d  = ^bus.d[WORD_W-1:DATA_W];

`ifdef CRC22_CHECK_WORDCNT_EN
   assign frame_ok = (ncrc_q == rx_full) & ~mark_err_q & mark_good & ~ovf_q;
`else
   assign frame_ok = (ncrc_q == rx_full) & ~mark_err_q & mark_good;
`endif

   // Frame FSM next state and registered-output next values
   always_comb begin
      state_d    = state_q;
      ncrc_d     = ncrc_q;
      rx_lo_d    = rx_lo_q;
      mark_err_d = mark_err_q;
      done_d     = 1'b0;
      crc_ok_d   = crc_ok_q;
      crc_err_d  = crc_err_q;
      calc_crc_d = calc_crc_q;
      rx_crc_d   = rx_crc_q;
`ifdef CRC22_CHECK_WORDCNT_EN
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      word_cnt_d = word_cnt_q;
`endif

      if (start && (state_q != StDone)) begin
         // A header always (re)starts a frame; any partial frame is dropped
         state_d    = bus.eof ? StCrcLo : StAccum;
         ncrc_d     = '0;
         mark_err_d = 1'b0;
         crc_ok_d   = 1'b0;
         crc_err_d  = 1'b0;
         calc_crc_d = '0;
         rx_crc_d   = '0;
`ifdef CRC22_CHECK_WORDCNT_EN
         cnt_d      = '0;
         ovf_d      = 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               // Stray words outside a frame are ignored
            end
            StAccum: begin
               if (bus.valid) begin
                  ncrc_d = ncrc_step;
`ifdef CRC22_CHECK_WORDCNT_EN
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == '1) begin
                     ovf_d = 1'b1;
                  end
`endif
                  if (bus.eof) begin
                     state_d = StCrcLo;
                  end
               end
            end
            StCrcLo: begin
               if (bus.valid) begin
                  rx_lo_d = bus.d[HALF_W-1:0];
                  if (!mark_good) begin
                     mark_err_d = 1'b1;
                  end
                  state_d = StCrcHi;
               end
            end
            StCrcHi: begin
               if (bus.valid) begin
                  done_d     = 1'b1;
                  calc_crc_d = ncrc_q;
                  rx_crc_d   = rx_full;
                  crc_ok_d   = frame_ok;
                  crc_err_d  = ~frame_ok;
`ifdef CRC22_CHECK_WORDCNT_EN
                  word_cnt_d = cnt_q;
`endif
                  state_d    = StDone;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ncrc_q     <= '0;
         rx_lo_q    <= '0;
         mark_err_q <= 1'b0;
         done_q     <= 1'b0;
         crc_ok_q   <= 1'b0;
         crc_err_q  <= 1'b0;
         calc_crc_q <= '0;
         rx_crc_q   <= '0;
`ifdef CRC22_CHECK_WORDCNT_EN
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         word_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ncrc_q     <= ncrc_d;
         rx_lo_q    <= rx_lo_d;
         mark_err_q <= mark_err_d;
         done_q     <= done_d;
         crc_ok_q   <= crc_ok_d;
         crc_err_q  <= crc_err_d;
         calc_crc_q <= calc_crc_d;
         rx_crc_q   <= rx_crc_d;
`ifdef CRC22_CHECK_WORDCNT_EN
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         word_cnt_q <= word_cnt_d;
`endif
      end
   end

   assign bus.done     = done_q;
   assign bus.crc_ok   = crc_ok_q;
   assign bus.crc_err  = crc_err_q;
   assign bus.calc_crc = calc_crc_q;
   assign bus.rx_crc   = rx_crc_q;
`ifdef CRC22_CHECK_WORDCNT_EN
   assign bus.word_cnt = word_cnt_q;
`endif

endmodule
